// File: rtl/fp_mul_pipe_param_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// The slave side is the multiplier; the master side feeds operands and drains results.
interface fp_mul_pipe_param_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   rnd_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         underflow;
    logic         invalid;
    logic         inexact;

    modport master (
        output in_valid, a, b, rnd_mode, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, invalid, inexact
    );

    modport slave (
        input  in_valid, a, b, rnd_mode, out_ready,
        output in_ready, out_valid, result, overflow, underflow, invalid, inexact
    );
endinterface

// File: rtl/fp_mul_pipe_param.sv
// Parametrised floating-point multiplier: decode/multiply, normalise, round/assemble.
// DAZ on inputs, FTZ on outputs, four rounding modes carried per operation.
module fp_mul_pipe_param #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input logic                clk,
    input logic                rst,
    fp_mul_pipe_param_if.slave io
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]     ONES    = '1;
    localparam logic [EXP_W-1:0]     ONES_M1 = ONES - 1'b1;
    localparam logic [W-1:0]         QNAN    = {1'b0, ONES, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic round_inc(input logic [1:0] mode, input logic sign,
                                       input logic lsb, input logic g, input logic s);
        case (mode)
            2'b00:   round_inc = g & (s | lsb);
            2'b01:   round_inc = 1'b0;
            2'b10:   round_inc = ~sign & (g | s);
            default: round_inc = sign & (g | s);
        endcase
    endfunction

    function automatic logic [W-1:0] sat_result(input logic [1:0] mode, input logic sign);
        logic [W-1:0] inf_v;
        logic [W-1:0] max_v;
        inf_v = {sign, ONES, {MAN_W{1'b0}}};
        max_v = {sign, ONES_M1, {MAN_W{1'b1}}};
        case (mode)
            2'b00:   sat_result = inf_v;
            2'b01:   sat_result = max_v;
            2'b10:   sat_result = sign ? max_v : inf_v;
            default: sat_result = sign ? inf_v : max_v;
        endcase
    endfunction

    logic stall;
    assign stall       = io.out_valid & ~io.out_ready;
    assign io.in_ready = ~stall;

    // ---- stage 0: decode and multiply ----
    logic                    sa, sb, sx;
    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        fa, fb;
    logic                    nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic                    spec_d, spec_inv_d;
    logic [W-1:0]            spec_res_d;
    logic [PW-1:0]           prod_d;
    logic signed [XW-1:0]    exp_d;

    assign {sa, ea, fa} = io.a;
    assign {sb, eb, fb} = io.b;
    assign sx     = sa ^ sb;
    assign nan_a  = (ea == ONES) & (|fa);
    assign nan_b  = (eb == ONES) & (|fb);
    assign inf_a  = (ea == ONES) & ~(|fa);
    assign inf_b  = (eb == ONES) & ~(|fb);
    assign zero_a = ~(|ea);
    assign zero_b = ~(|eb);
    assign prod_d = PW'({1'b1, fa}) * PW'({1'b1, fb});
    assign exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    always_comb begin
        spec_d     = 1'b1;
        spec_inv_d = 1'b0;
        spec_res_d = QNAN;
        if (nan_a | nan_b) begin
            spec_res_d = QNAN;
        end else if ((inf_a & zero_b) | (zero_a & inf_b)) begin
            spec_inv_d = 1'b1;
        end else if (inf_a | inf_b) begin
            spec_res_d = {sx, ONES, {MAN_W{1'b0}}};
        end else if (zero_a | zero_b) begin
            spec_res_d = {sx, {(W-1){1'b0}}};
        end else begin
            spec_d = 1'b0;
        end
    end

    logic                 vld_p0, sign_p0, spec_p0, spec_inv_p0;
    logic [1:0]           rnd_p0;
    logic [W-1:0]         spec_res_p0;
    logic signed [XW-1:0] exp_p0;
    logic [PW-1:0]        prod_p0;

    // ---- stage 1: normalise, split into kept fraction / guard / sticky ----
    logic [MAN_W-1:0]     frac_n;
    logic                 g_n, s_n;
    logic signed [XW-1:0] exp_n;

    always_comb begin
        if (prod_p0[PW-1]) begin
            frac_n = prod_p0[PW-2 -: MAN_W];
            g_n    = prod_p0[MAN_W];
            s_n    = |prod_p0[MAN_W-1:0];
            exp_n  = exp_p0 + XW'(1);
        end else begin
            frac_n = prod_p0[PW-3 -: MAN_W];
            g_n    = prod_p0[MAN_W-1];
            s_n    = |prod_p0[MAN_W-2:0];
            exp_n  = exp_p0;
        end
    end

    logic                 vld_p1, sign_p1, spec_p1, spec_inv_p1, g_p1, s_p1;
    logic [1:0]           rnd_p1;
    logic [W-1:0]         spec_res_p1;
    logic signed [XW-1:0] exp_p1;
    logic [MAN_W-1:0]     frac_p1;

    // ---- stage 2: round, classify range, assemble ----
    logic                 inc_r;
    logic [MAN_W:0]       frac_r;
    logic signed [XW-1:0] exp_r;
    logic [W-1:0]         res_d2;
    logic                 ovf_d2, unf_d2, inv_d2, inx_d2;

    always_comb begin
        inc_r  = round_inc(rnd_p1, sign_p1, frac_p1[0], g_p1, s_p1);
        frac_r = {1'b0, frac_p1} + (MAN_W+1)'(inc_r);
        // a fraction carry leaves the low bits zero, only the exponent moves
        exp_r  = frac_r[MAN_W] ? exp_p1 + XW'(1) : exp_p1;
        res_d2 = {sign_p1, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
        ovf_d2 = 1'b0;
        unf_d2 = 1'b0;
        inv_d2 = 1'b0;
        inx_d2 = g_p1 | s_p1;
        if (spec_p1) begin
            res_d2 = spec_res_p1;
            inv_d2 = spec_inv_p1;
            inx_d2 = 1'b0;
        end else if (exp_r >= EXP_MAX) begin
            res_d2 = sat_result(rnd_p1, sign_p1);
            ovf_d2 = 1'b1;
            inx_d2 = 1'b1;
        end else if (exp_r[XW-1] | ~(|exp_r)) begin
            res_d2 = {sign_p1, {(W-1){1'b0}}};
            unf_d2 = 1'b1;
            inx_d2 = 1'b1;
        end
    end

    logic         vld_p2, ovf_p2, unf_p2, inv_p2, inx_p2;
    logic [W-1:0] res_p2;

    always_ff @(posedge clk) begin
        if (!stall) begin
            sign_p0     <= sx;
            rnd_p0      <= io.rnd_mode;
            spec_p0     <= spec_d;
            spec_inv_p0 <= spec_inv_d;
            spec_res_p0 <= spec_res_d;
            exp_p0      <= exp_d;
            prod_p0     <= prod_d;
            sign_p1     <= sign_p0;
            rnd_p1      <= rnd_p0;
            spec_p1     <= spec_p0;
            spec_inv_p1 <= spec_inv_p0;
            spec_res_p1 <= spec_res_p0;
            exp_p1      <= exp_n;
            frac_p1     <= frac_n;
            g_p1        <= g_n;
            s_p1        <= s_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            ovf_p2 <= 1'b0;
            unf_p2 <= 1'b0;
            inv_p2 <= 1'b0;
            inx_p2 <= 1'b0;
        end else if (!stall) begin
            vld_p0 <= io.in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2 <= res_d2;
                ovf_p2 <= ovf_d2;
                unf_p2 <= unf_d2;
                inv_p2 <= inv_d2;
                inx_p2 <= inx_d2;
            end
        end
    end

    assign io.out_valid = vld_p2;
    assign io.result    = res_p2;
    assign io.overflow  = ovf_p2;
    assign io.underflow = unf_p2;
    assign io.invalid   = inv_p2;
    assign io.inexact   = inx_p2;
endmodule

// File: tb/tb_fp_mul_pipe_param.sv
// Bench for fp_mul_pipe_param: directed fp16 vectors with literal expectations,
// plus a scoreboard fed by an exact-arithmetic reference model.
module tb_fp_mul_pipe_param;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EMAX  = (1 << EXP_W) - 1;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam longint HID = 64'sd1 << MAN_W;
    localparam logic [EXP_W-1:0] ONES    = '1;
    localparam logic [EXP_W-1:0] ONES_M1 = ONES - 1'b1;
    localparam logic [MAN_W-1:0] MZERO   = '0;
    localparam logic [MAN_W-1:0] MONES   = '1;
    localparam logic [W-1:0]     QNAN    = {1'b0, ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
        logic         unf;
        logic         inv;
        logic         inx;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    fp_mul_pipe_param_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) io ();

    fp_mul_pipe_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    // Exact product, then quantise by integer remainder against half an ulp.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] m);
        exp_t   r;
        int     ea, eb, e, k, sh;
        longint fa, fb, p, q, rem, half;
        bit     sg, up, to_inf;
        r  = '0;
        ea = int'(a[W-2:MAN_W]);
        eb = int'(b[W-2:MAN_W]);
        fa = longint'(a[MAN_W-1:0]);
        fb = longint'(b[MAN_W-1:0]);
        sg = a[W-1] ^ b[W-1];
        if ((ea == EMAX && fa != 0) || (eb == EMAX && fb != 0)) begin
            r.res = QNAN;
        end else if ((ea == EMAX && eb == 0) || (ea == 0 && eb == EMAX)) begin
            r.res = QNAN;
            r.inv = 1'b1;
        end else if (ea == EMAX || eb == EMAX) begin
            r.res = {sg, ONES, MZERO};
        end else if (ea == 0 || eb == 0) begin
            r.res = {sg, {(W-1){1'b0}}};
        end else begin
            p = (fa + HID) * (fb + HID);
            k = 0;
            for (int i = 0; i < 64; i++) if (p[i]) k = i;
            e    = ea + eb - BIAS + k - 2 * MAN_W;
            sh   = k - MAN_W;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'sd1 << (sh - 1);
            case (m)
                2'd0:    up = (rem > half) || (rem == half && q[0]);
                2'd1:    up = 1'b0;
                2'd2:    up = !sg && rem != 0;
                default: up = sg && rem != 0;
            endcase
            if (up) q = q + 1;
            if (q == (HID << 1)) begin
                q = q >> 1;
                e = e + 1;
            end
            r.inx  = (rem != 0);
            to_inf = (m == 2'd0) || (m == 2'd2 && !sg) || (m == 2'd3 && sg);
            if (e >= EMAX) begin
                r.ovf = 1'b1;
                r.inx = 1'b1;
                r.res = to_inf ? {sg, ONES, MZERO} : {sg, ONES_M1, MONES};
            end else if (e <= 0) begin
                r.unf = 1'b1;
                r.inx = 1'b1;
                r.res = {sg, {(W-1){1'b0}}};
            end else begin
                r.res = {sg, e[EXP_W-1:0], q[MAN_W-1:0]};
            end
        end
        return r;
    endfunction

    exp_t         sb_q[$];
    bit           was_stall = 1'b0;
    logic [W+4:0] held;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            was_stall = 1'b0;
        end else begin
            checks++;
            if (io.in_ready !== !(io.out_valid && !io.out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b want %b", io.in_ready,
                         !(io.out_valid && !io.out_ready));
            end
            if (was_stall) begin
                checks++;
                if ({io.out_valid, io.result, io.overflow, io.underflow, io.invalid,
                     io.inexact} !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got %h want %h",
                             {io.out_valid, io.result, io.overflow, io.underflow,
                              io.invalid, io.inexact}, held);
                end
            end
            if (io.out_valid && io.out_ready) begin
                n_out++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got res=%h with no pending op", io.result);
                end else begin
                    e = sb_q.pop_front();
                    if ({io.result, io.overflow, io.underflow, io.invalid, io.inexact} !== e) begin
                        errors++;
                        $display("FAIL model: got res=%h flags=%b want res=%h flags=%b",
                                 io.result, {io.overflow, io.underflow, io.invalid, io.inexact},
                                 e.res, {e.ovf, e.unf, e.inv, e.inx});
                    end
                end
            end
            if (io.in_valid && io.in_ready) sb_q.push_back(model(io.a, io.b, io.rnd_mode));
            was_stall = io.out_valid && !io.out_ready;
            held = {io.out_valid, io.result, io.overflow, io.underflow, io.invalid, io.inexact};
        end
    end

    // flags are {overflow, underflow, invalid, inexact}
    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic [1:0] m, input logic [W-1:0] er, input logic [3:0] ef,
                         input bit chk_lat);
        int n;
        io.in_valid = 1'b1;
        io.a        = ta;
        io.b        = tbv;
        io.rnd_mode = m;
        @(posedge clk);
        #1 io.in_valid = 1'b0;
        n = 1;
        while (!io.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!io.out_valid) begin
            errors++;
            $display("FAIL %s timeout: out_valid still 0 after %0d cycles", name, n);
        end else begin
            if (chk_lat) begin
                checks++;
                if (n != 3) begin
                    errors++;
                    $display("FAIL %s latency: got %0d want 3", name, n);
                end
            end
            if ({io.result, io.overflow, io.underflow, io.invalid, io.inexact} !== {er, ef}) begin
                errors++;
                $display("FAIL %s: got res=%h flags=%b want res=%h flags=%b", name, io.result,
                         {io.overflow, io.underflow, io.invalid, io.inexact}, er, ef);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] st_a [6] = '{16'h3C01, 16'h4000, 16'h7BFF, 16'h3DA8, 16'hFC00, 16'h0400};
    logic [W-1:0] st_b [6] = '{16'h3C01, 16'h4200, 16'h7BFF, 16'h3DA8, 16'h4000, 16'h0400};
    logic [1:0]   st_m [6] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0};

    initial begin
        int base;
        bit acc;
        clk          = 1'b0;
        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        io.a         = '0;
        io.b         = '0;
        io.rnd_mode  = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({io.out_valid, io.result, io.overflow, io.underflow, io.invalid, io.inexact,
             io.in_ready} !== {1'b0, {W{1'b0}}, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got v=%b res=%h rdy=%b", io.out_valid, io.result,
                     io.in_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op("one_x_one",   16'h3C00, 16'h3C00, 2'd0, 16'h3C00, 4'b0000, 1'b0);
        do_op("two_x_three", 16'h4000, 16'h4200, 2'd0, 16'h4600, 4'b0000, 1'b1);
        do_op("rne_inexact", 16'h3C01, 16'h3C01, 2'd0, 16'h3C02, 4'b0001, 1'b0);
        do_op("rup_inexact", 16'h3C01, 16'h3C01, 2'd2, 16'h3C03, 4'b0001, 1'b0);
        do_op("rtz_inexact", 16'h3C01, 16'h3C01, 2'd1, 16'h3C02, 4'b0001, 1'b0);
        do_op("rdn_neg",     16'h3C01, 16'hBC01, 2'd3, 16'hBC03, 4'b0001, 1'b0);
        do_op("round_carry", 16'h3DA8, 16'h3DA8, 2'd0, 16'h4000, 4'b0001, 1'b0);
        do_op("ovf_rne",     16'h7BFF, 16'h7BFF, 2'd0, 16'h7C00, 4'b1001, 1'b0);
        do_op("ovf_rtz",     16'h7BFF, 16'h7BFF, 2'd1, 16'h7BFF, 4'b1001, 1'b0);
        do_op("ovf_rup_neg", 16'hFBFF, 16'h7BFF, 2'd2, 16'hFBFF, 4'b1001, 1'b0);
        do_op("ovf_rdn_neg", 16'hFBFF, 16'h7BFF, 2'd3, 16'hFC00, 4'b1001, 1'b0);
        do_op("inf_x_zero",  16'h7C00, 16'h0000, 2'd0, 16'h7E00, 4'b0010, 1'b0);
        do_op("nan_in",      16'h7E01, 16'h3C00, 2'd0, 16'h7E00, 4'b0000, 1'b0);
        do_op("ninf_x_two",  16'hFC00, 16'h4000, 2'd0, 16'hFC00, 4'b0000, 1'b0);
        do_op("nzero_nzero", 16'h8000, 16'hC000, 2'd0, 16'h0000, 4'b0000, 1'b0);
        do_op("underflow",   16'h0400, 16'h0400, 2'd0, 16'h0000, 4'b0101, 1'b0);

        // streaming with a 5-cycle output stall in the middle
        base = n_out;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 io.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 io.out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 6; i++) begin
            io.in_valid = 1'b1;
            io.a        = st_a[i];
            io.b        = st_b[i];
            io.rnd_mode = st_m[i];
            for (int g = 0; g < 50; g++) begin
                @(negedge clk);
                acc = io.in_ready;
                @(posedge clk);
                #1;
                if (acc) break;
            end
        end
        io.in_valid = 1'b0;
        for (int w = 0; w < 100 && n_out < base + 6; w++) @(posedge clk);
        #1;
        checks++;
        if (n_out - base != 6 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d outputs pending %0d want 6 pending 0",
                     n_out - base, sb_q.size());
        end

        // reset with one op at the output and one behind it
        io.in_valid = 1'b1;
        io.a        = 16'h4000;
        io.b        = 16'h4000;
        @(posedge clk);
        #1 io.a = 16'h4200;
        @(posedge clk);
        #1 io.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (io.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: got %b want 1", io.out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({io.out_valid, io.result, io.overflow, io.underflow, io.invalid, io.inexact}
            !== {1'b0, {W{1'b0}}, 4'b0000}) begin
            errors++;
            $display("FAIL mid_reset: got v=%b res=%h want v=0 res=0000", io.out_valid,
                     io.result);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (io.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_after_reset: got out_valid=%b want 0 at cycle %0d",
                         io.out_valid, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
